// File: rtl/spi_regfile_pkg.sv
// spi_regfile_pkg: shared FSM encoding, write flag and frame length for the SPI register-file target.
package spi_regfile_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_END} state_e;
  localparam logic RW_WRITE = 1'b1;
  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-flop synchroniser plus a delay flop giving one-clk rise/fall pulses.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              dly_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end
  assign rise_o = sync_q[STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[STAGES-1] & dly_q;
endmodule

// File: rtl/spi_regfile_peripheral.sv
// spi_regfile_peripheral: SPI mode-0 target with framed-commit register bank and read-back.
// Optional SPI_ERR_CNT_EN adds a saturating frame-error counter at address NUM_REGS.
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int                NUM_REGS    = 5,
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 7,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);
  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CMD_END = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_LEN);
  logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_s, commit;
  logic [SYNC_STAGES-1:0] copi_q;
  state_e                 state_q;
  logic [CNT_W-1:0]       bit_cnt_q, cnt_inc;
  logic [ADDR_W-1:0]      cmd_sr_q, addr_q;
  logic [ADDR_W:0]        cmd_nx;
  logic                   rw_q, ovr_q, cipo_q, cipo_oe_q, frame_err_q;
  logic [DATA_W-1:0]      rx_sr_q, tx_sr_q;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]    wr_strobe_q;
`ifdef SPI_ERR_CNT_EN
  logic [7:0]             err_cnt_q;
`endif
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d_i(sclk), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
    .clk(clk), .rst(rst), .d_i(ncs), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );
  always_ff @(posedge clk) begin
    copi_q <= rst ? '0 : {copi_q[SYNC_STAGES-2:0], copi};
  end
  assign copi_s  = copi_q[SYNC_STAGES-1];
  assign cmd_nx  = {cmd_sr_q, copi_s};
  assign cnt_inc = bit_cnt_q + CNT_W'(1);
  assign commit  = ncs_rise && state_q == WAIT_END && rw_q == RW_WRITE && !ovr_q;
  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) if (int'(a) == k) rd_data = regs_q[k];
`ifdef SPI_ERR_CNT_EN
    if (int'(a) == NUM_REGS) rd_data = DATA_W'(err_cnt_q);
`endif
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cmd_sr_q    <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      ovr_q       <= 1'b0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VAL;
    end else begin
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
      // chip-select edges outrank any sclk edge seen in the same clk
      if (ncs_fall) begin
        frame_err_q <= state_q != IDLE;
        state_q     <= CMD;
        bit_cnt_q   <= '0;
        cmd_sr_q    <= '0;
        rx_sr_q     <= '0;
        tx_sr_q     <= '0;
        ovr_q       <= 1'b0;
        cipo_q      <= 1'b0;
        cipo_oe_q   <= 1'b1;
      end else if (ncs_rise) begin
        frame_err_q <= state_q == CMD || state_q == DATA || (state_q == WAIT_END && ovr_q);
        state_q     <= IDLE;
        cipo_q      <= 1'b0;
        cipo_oe_q   <= 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (commit && int'(addr_q) == k) begin
            regs_q[k]      <= rx_sr_q;
            wr_strobe_q[k] <= 1'b1;
          end
        end
      end else if (sclk_rise) begin
        if (state_q == CMD) begin
          cmd_sr_q  <= cmd_nx[ADDR_W-1:0];
          bit_cnt_q <= cnt_inc;
          if (cnt_inc == CMD_END) begin
            rw_q    <= cmd_nx[ADDR_W];
            addr_q  <= cmd_nx[ADDR_W-1:0];
            tx_sr_q <= cmd_nx[ADDR_W] == RW_WRITE ? '0 : rd_data(cmd_nx[ADDR_W-1:0]);
            state_q <= DATA;
          end
        end else if (state_q == DATA) begin
          rx_sr_q   <= {rx_sr_q[DATA_W-2:0], copi_s};
          bit_cnt_q <= cnt_inc;
          if (cnt_inc == FRAME_END) state_q <= WAIT_END;
        end else if (state_q == WAIT_END) begin
          ovr_q <= 1'b1;
        end
      end else if (sclk_fall && state_q == DATA) begin
        cipo_q  <= tx_sr_q[DATA_W-1];
        tx_sr_q <= tx_sr_q << 1;
      end
    end
  end
`ifdef SPI_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || (commit && int'(addr_q) == NUM_REGS)) err_cnt_q <= '0;
    else if (frame_err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end
`endif
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[i*DATA_W +: DATA_W] = regs_q[i];
  end
  assign cipo      = cipo_q;
  assign cipo_oe   = cipo_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// tb_spi_regfile_peripheral: directed plus random SPI frames scored against an array model of the register bank.
module tb_spi_regfile_peripheral;
  localparam int NR = 5, DW = 8, AW = 7, SS = 2, FL = 1 + AW + DW, H = 5;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
  logic cipo, cipo_oe, frame_err;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0] wr_strobe;
  spi_regfile_peripheral #(
    .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(SS), .RESET_VAL('0)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo), .cipo_oe(cipo_oe),
    .reg_q(reg_q), .wr_strobe(wr_strobe), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic          err;
    logic [NR-1:0] strobe;
    logic [DW-1:0] data;
  } ev_t;
  ev_t ev_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] model [NR];
  int err_cnt = 0, errors = 0, checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] expect_rd(input int a);
    if (a < NR) return model[a];
`ifdef SPI_ERR_CNT_EN
    if (a == NR) return DW'(err_cnt);
`endif
    return '0;
  endfunction
  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = model[i];
    return r;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // controller side: predicts the frame outcome from the model, then clocks nbits out
  task automatic frame(input logic rw, input int addr, input logic [DW-1:0] data, input int nbits, input bit rst_mid);
    logic [FL-1:0] w;
    ev_t e;
    w = {rw, AW'(addr), data};
    if (rst_mid) begin
    end else if (nbits != FL) begin
      e.err = 1'b1; e.strobe = '0; e.data = '0;
      ev_q.push_back(e);
      if (err_cnt < 255) err_cnt++;
    end else if (rw) begin
      if (addr < NR) begin
        model[addr] = data;
        e.err = 1'b0; e.strobe = NR'(1) << addr; e.data = data;
        ev_q.push_back(e);
      end
`ifdef SPI_ERR_CNT_EN
      else if (addr == NR) err_cnt = 0;
`endif
    end else rd_q.push_back(expect_rd(addr));
    tick(1);
    ncs = 1'b0;
    tick(H);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < FL) ? w[FL-1-i] : 1'b0;
      tick(H);
      sclk = 1'b1;
      tick(H);
      sclk = 1'b0;
    end
    copi = 1'b0;
    if (rst_mid) begin
      rst = 1'b1;
      ncs = 1'b1;
      for (int i = 0; i < NR; i++) model[i] = '0;
      err_cnt = 0;
      tick(3);
      rst = 1'b0;
    end else begin
      tick(H);
      ncs = 1'b1;
    end
    tick(3 * H);
  endtask
  // observes pins and DUT pulses only; pops expectations as outputs appear
  task automatic monitor();
    logic ps = 1'b0, pn = 1'b1;
    int n = 0, hc = 0;
    logic [FL-1:0] fb = '0;
    logic [DW-1:0] rb = '0;
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ps = 1'b0; pn = 1'b1; n = 0; hc = 0;
      end else begin
        if (frame_err || |wr_strobe) begin
          chk("event_expected", ev_q.size() > 0, 1);
          if (ev_q.size() > 0) begin
            e = ev_q.pop_front();
            chk("frame_err", frame_err, e.err);
            chk("wr_strobe", wr_strobe, e.strobe);
            for (int i = 0; i < NR; i++) if (e.strobe[i]) chk("reg_commit", reg_q[i*DW +: DW], e.data);
          end
        end
        if (sclk && !ps && !ncs) begin
          n++;
          fb = {fb[FL-2:0], copi};
          if (n > 1 + AW) rb = {rb[DW-2:0], cipo};
          chk("cipo_oe_active", cipo_oe, 1);
        end
        if (!ncs && pn) n = 0;
        if (ncs && !pn) begin
          hc = 0;
          if (n == FL && fb[FL-1] == 1'b0) begin
            chk("read_expected", rd_q.size() > 0, 1);
            if (rd_q.size() > 0) chk("read_data", rb, rd_q.pop_front());
          end
        end
        if (ncs) hc++;
        if (ncs && hc == SS + 2) begin
          chk("missing_event", ev_q.size(), 0);
          chk("reg_q", reg_q, model_flat());
          chk("cipo_oe_idle", cipo_oe, 0);
          chk("cipo_idle", cipo, 0);
        end
        ps = sclk;
        pn = ncs;
      end
    end
  endtask
  initial begin
    int a, r, nb;
    for (int i = 0; i < NR; i++) model[i] = '0;
    fork monitor(); join_none
    tick(3);
    rst = 1'b0;
    tick(10);
    frame(1'b1, 3, 8'h00, 5, 1'b1);
    frame(1'b1, 3, 8'h11, FL, 1'b0);
    frame(1'b1, 2, 8'hA5, FL, 1'b0);
    frame(1'b1, 4, 8'h3C, FL, 1'b0);
    frame(1'b0, 4, 8'h00, FL, 1'b0);
    frame(1'b1, 0, 8'hFF, 12, 1'b0);
    frame(1'b1, 1, 8'h5A, 17, 1'b0);
    frame(1'b0, 127, 8'h00, FL, 1'b0);
    repeat (3) frame(1'b1, 0, 8'h77, 10, 1'b0);
    frame(1'b0, NR, 8'h00, FL, 1'b0);
    frame(1'b1, NR, 8'h9C, FL, 1'b0);
    frame(1'b0, NR, 8'h00, FL, 1'b0);
    for (int k = 0; k < 50; k++) begin
      r = int'($urandom_range(0, 9));
      a = (r < 7) ? r : (r == 7) ? 127 : int'($urandom_range(0, 127));
      nb = ($urandom_range(0, 9) < 7) ? FL :
           ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 15)) : FL + 1 + int'($urandom_range(0, 1));
      frame(1'($urandom_range(0, 1)), a, 8'($urandom), nb, 1'b0);
    end
    tick(20);
    chk("ev_queue_drained", ev_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
